// File: rtl/pri_enc_sched_pkg.sv
// Shared types and helpers for the priority-encoding request scheduler.
package pri_pkg;

  typedef enum logic {
    PRI_FIXED = 1'b0,
    PRI_RR    = 1'b1
  } pri_mode_e;

  // Index width that never collapses to zero bits.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pri_enc_sched_comb.sv
// Combinational highest-set-index encoder with a found flag.
module pri_enc_comb #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        idx   = W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pri_enc_sched.sv
// Registered N-channel request scheduler: latches requests as pending and
// hands out one channel index at a time on a valid/ready port.
module pri_enc_sched
  import pri_pkg::*;
#(
  parameter  int N  = 8,
  parameter  int RR = 0,
  localparam int W  = clog2_safe(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] pend,
  output logic         any_pend
);

  logic [N-1:0] elig, below, lo_vec, claim, pend_nxt;
  logic [W-1:0] ptr, lo_idx, hi_idx, sel;
  logic         lo_found, hi_found, load;

  assign elig = (pend | req) & ~mask;

  // Channels strictly below ptr are searched first; ptr stays 0 in fixed
  // mode so this vector is empty and the full-vector search decides alone.
  always_comb begin
    below = '0;
    for (int k = 0; k < N; k++) below[k] = (k < int'(ptr));
  end

  assign lo_vec = elig & below;

  pri_enc_comb #(.N(N), .W(W)) u_enc_lo (
    .vec   (lo_vec),
    .idx   (lo_idx),
    .found (lo_found)
  );

  pri_enc_comb #(.N(N), .W(W)) u_enc_hi (
    .vec   (elig),
    .idx   (hi_idx),
    .found (hi_found)
  );

  assign sel      = lo_found ? lo_idx : hi_idx;
  assign load     = (~out_valid | out_ready) & hi_found;
  assign claim    = load ? ({{(N-1){1'b0}}, 1'b1} << sel) : '0;
  assign pend_nxt = (pend | req) & ~claim;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend      <= '0;
      any_pend  <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      ptr       <= '0;
    end else begin
      pend     <= pend_nxt;
      any_pend <= |pend_nxt;
      if (load) begin
        out_idx   <= sel;
        out_valid <= 1'b1;
        if (RR == int'(PRI_RR)) ptr <= sel;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pri_enc_sched.sv
// Scoreboard bench for pri_enc_sched: three configurations (N=8 fixed,
// N=8 round-robin, N=5 round-robin) against a behavioural reference model.
module tb_pri_enc_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] req_v  [3];
  logic [7:0] mask_v [3];
  logic       rdy    [3];

  logic       v0, v1, v2, a0, a1, a2;
  logic [2:0] i0, i1, i2;
  logic [7:0] p0, p1;
  logic [4:0] p2;

  pri_enc_sched #(.N(8), .RR(0)) u_fix8 (
    .clk(clk), .rst(rst), .req(req_v[0]), .mask(mask_v[0]),
    .out_valid(v0), .out_ready(rdy[0]), .out_idx(i0), .pend(p0), .any_pend(a0)
  );

  pri_enc_sched #(.N(8), .RR(1)) u_rr8 (
    .clk(clk), .rst(rst), .req(req_v[1]), .mask(mask_v[1]),
    .out_valid(v1), .out_ready(rdy[1]), .out_idx(i1), .pend(p1), .any_pend(a1)
  );

  pri_enc_sched #(.N(5), .RR(1)) u_rr5 (
    .clk(clk), .rst(rst), .req(req_v[2][4:0]), .mask(mask_v[2][4:0]),
    .out_valid(v2), .out_ready(rdy[2]), .out_idx(i2), .pend(p2), .any_pend(a2)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  int nn  [3] = '{8, 8, 5};
  int rrm [3] = '{0, 1, 1};

  // Reference model state
  bit   mpend [3][8];
  bit   mval  [3];
  int   midx  [3];
  int   mptr  [3];
  int   sbq   [3][$];

  task automatic chk(input string name, input int d, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s dut%0d t=%0t actual=%0d expected=%0d", name, d, $time, act, exp);
  endtask

  task automatic model_step(input int d);
    int  n;
    int  pick;
    bit  cand [8];
    n = nn[d];
    if (rst) begin
      for (int k = 0; k < 8; k++) mpend[d][k] = 1'b0;
      mval[d] = 1'b0;
      midx[d] = 0;
      mptr[d] = 0;
      sbq[d].delete();
      return;
    end
    for (int k = 0; k < n; k++) begin
      mpend[d][k] = mpend[d][k] | req_v[d][k];
      cand[k]     = mpend[d][k] & ~mask_v[d][k];
    end
    pick = -1;
    if (!mval[d] || rdy[d]) begin
      if (rrm[d] == 0) begin
        for (int k = n - 1; k >= 0; k--)
          if (pick < 0 && cand[k]) pick = k;
      end else begin
        // descending from ptr-1 with wrap, ending at ptr itself
        for (int j = 1; j <= n; j++) begin
          int k;
          k = (mptr[d] - j + n) % n;
          if (pick < 0 && cand[k]) pick = k;
        end
      end
    end
    if (pick >= 0) begin
      sbq[d].push_back(pick);
      mval[d]        = 1'b1;
      midx[d]        = pick;
      mpend[d][pick] = 1'b0;
      if (rrm[d] == 1) mptr[d] = pick;
    end else if (mval[d] && rdy[d]) begin
      mval[d] = 1'b0;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      for (int d = 0; d < 3; d++) model_step(d);
    end
  end

  // Monitor: compares status every cycle and pops the scoreboard on accept.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        logic       dv, da;
        logic [2:0] di;
        logic [7:0] dp;
        int         mp, ma;
        case (d)
          0:       begin dv = v0; di = i0; dp = p0;          da = a0; end
          1:       begin dv = v1; di = i1; dp = p1;          da = a1; end
          default: begin dv = v2; di = i2; dp = {3'b0, p2}; da = a2; end
        endcase
        mp = 0;
        for (int k = 0; k < nn[d]; k++) if (mpend[d][k]) mp |= (1 << k);
        ma = (mp != 0) ? 1 : 0;
        chk("out_valid", d, int'(dv), int'(mval[d]));
        chk("out_idx",   d, int'(di), midx[d]);
        chk("pend",      d, int'(dp), mp);
        chk("any_pend",  d, int'(da), ma);
        if (dv && rdy[d] && !rst) begin
          if (sbq[d].size() == 0) begin
            total_cnt++;
            $display("FAIL accept_unexpected dut%0d t=%0t actual=%0d expected=none", d, $time, di);
          end else begin
            chk("accept_idx", d, int'(di), sbq[d].pop_front());
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      req_v[d]  = 8'hFF;
      mask_v[d] = 8'h00;
      rdy[d]    = 1'b1;
    end
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    for (int d = 0; d < 3; d++) req_v[d] = 8'h00;
    tick(2);

    // Fixed priority on a multi-bit pattern: 5, 2, 1
    req_v[0] = 8'b0010_0110;
    tick(1);
    req_v[0] = 8'h00;
    tick(5);

    // Stall with a second request arriving behind the held one
    rdy[0]   = 1'b0;
    req_v[0] = 8'h08;
    tick(1);
    req_v[0] = 8'h40;
    tick(1);
    req_v[0] = 8'h00;
    tick(3);
    rdy[0] = 1'b1;
    tick(4);

    // Masked channel stays pending until unmasked
    mask_v[0] = 8'h80;
    req_v[0]  = 8'h81;
    tick(1);
    req_v[0] = 8'h00;
    tick(3);
    mask_v[0] = 8'h00;
    tick(3);

    // Round-robin, N=8, all requesting
    req_v[1] = 8'hFF;
    tick(20);
    req_v[1] = 8'h00;
    tick(10);

    // Round-robin, N=5, channels 0 and 4 held
    req_v[2] = 8'h11;
    tick(12);
    req_v[2] = 8'h00;
    tick(6);

    // Random traffic, including stalls, masks and occasional reset
    for (int c = 0; c < 1500; c++) begin
      for (int d = 0; d < 3; d++) begin
        req_v[d]  = 8'($urandom & $urandom & $urandom);
        mask_v[d] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
        rdy[d]    = ($urandom_range(0, 3) != 0);
        if (d == 2) begin
          req_v[d]  = req_v[d] & 8'h1F;
          mask_v[d] = mask_v[d] & 8'h1F;
        end
      end
      rst = ($urandom_range(0, 199) == 0);
      tick(1);
    end
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      req_v[d]  = 8'h00;
      mask_v[d] = 8'h00;
      rdy[d]    = 1'b1;
    end
    tick(12);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
